// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with a hold-time limit.
// A grant is issued one cycle after a request is seen in IDLE, is held until
// release, loss of the holder's request, or the hold limit, and is always
// followed by at least one IDLE cycle before the next grant.
module rr_arbiter_8 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold counter value seen in the last cycle a grant is allowed to live.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [2:0]  id_q, id_d;
  logic        vld_q, vld_d;
  logic        to_q, to_d;

  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  win_id;
  logic [7:0]  win_onehot;
  logic        any_req;
  logic        held_req;
  logic        limit_hit;
  logic        grant_end;

  // Rotate requests so the pointer position becomes bit 0, then take the
  // lowest set bit; adding the pointer back gives the wrapped winner index.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr_q +: 8];
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
    win_id  = ptr_q + win_off;
    any_req = |req;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_id == 3'(gi));
    end
  endgenerate

  assign held_req  = req[id_q];
  assign limit_hit = (cnt_q == LIMIT);
  assign grant_end = rel | ~held_req | limit_hit;

  // Next-state and registered-output values for the two-state arbiter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && any_req) begin
          state_d = GRANT;
          gnt_d   = win_onehot;
          id_d    = win_id;
          vld_d   = 1'b1;
          cnt_d   = 16'd0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_d = IDLE;
          gnt_d   = 8'd0;
          id_d    = 3'd0;
          vld_d   = 1'b0;
          cnt_d   = 16'd0;
          ptr_d   = id_q + 3'd1;
          // A release in the limit cycle takes precedence over the timeout.
          to_d    = limit_hit & ~rel & held_req;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 16'd0;
      gnt_q   <= 8'd0;
      id_q    <= 3'd0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: two instances (hold limit 4 and 1) share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rel;
  logic [7:0] req;

  logic [7:0] gnt0, gnt1;
  logic [2:0] id0, id1;
  logic       vld0, vld1, to0, to1;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.TIMEOUT(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req), .rel(rel),
    .gnt(gnt0), .gnt_id(id0), .gnt_vld(vld0), .timeout(to0)
  );

  rr_arbiter_8 #(.TIMEOUT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .rel(rel),
    .gnt(gnt1), .gnt_id(id1), .gnt_vld(vld1), .timeout(to1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural model: who holds the grant, how many cycles it has been held,
  // where the next search starts, and whether a timeout pulse is due.
  bit m_busy [2];
  int m_holder [2];
  int m_held [2];
  int m_ptr [2];
  bit m_pulse [2];
  int m_limit [2] = '{4, 1};

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      m_pulse[m] = 1'b0;
      if (!rst) begin
        m_busy[m] = 1'b0; m_holder[m] = 0; m_held[m] = 0; m_ptr[m] = 0;
      end else if (m_busy[m]) begin
        m_held[m] = m_held[m] + 1;
        if (rel || !req[m_holder[m]] || m_held[m] == m_limit[m]) begin
          m_pulse[m] = (m_held[m] == m_limit[m]) && !rel && req[m_holder[m]];
          m_busy[m]  = 1'b0;
          m_ptr[m]   = (m_holder[m] + 1) % 8;
        end
      end else if (en && req != 8'd0) begin
        bit found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          int idx = (m_ptr[m] + k) % 8;
          if (!found && req[idx]) begin
            found = 1'b1;
            m_holder[m] = idx;
          end
        end
        m_busy[m] = 1'b1;
        m_held[m] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] eg [2];
    logic [2:0] ei [2];
    for (int m = 0; m < 2; m++) begin
      eg[m] = m_busy[m] ? (8'h01 << m_holder[m]) : 8'h00;
      ei[m] = m_busy[m] ? 3'(m_holder[m]) : 3'd0;
    end
    chk("t4_gnt", 32'(gnt0), 32'(eg[0]));
    chk("t4_gnt_id", 32'(id0), 32'(ei[0]));
    chk("t4_gnt_vld", 32'(vld0), 32'(m_busy[0]));
    chk("t4_timeout", 32'(to0), 32'(m_pulse[0]));
    chk("t1_gnt", 32'(gnt1), 32'(eg[1]));
    chk("t1_gnt_id", 32'(id1), 32'(ei[1]));
    chk("t1_gnt_vld", 32'(vld1), 32'(m_busy[1]));
    chk("t1_timeout", 32'(to1), 32'(m_pulse[1]));
  endtask

  // One transaction: drive inputs at the falling edge, let one rising edge
  // pass, then compare outputs at the next falling edge.
  task automatic step(input bit r_i, input bit e_i, input logic [7:0] q_i, input bit l_i);
    rst = r_i; en = e_i; req = q_i; rel = l_i;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    $display("t=%0t rst=%0b en=%0b req=%02h rel=%0b | t4 vld=%0b id=%0d to=%0b | t1 vld=%0b id=%0d to=%0b",
             $time, r_i, e_i, q_i, l_i, vld0, id0, to0, vld1, id1, to1);
  endtask

  initial begin
    logic [7:0] rq;
    rst = 1'b0; en = 1'b0; req = 8'd0; rel = 1'b0;
    @(negedge clk);

    // Reset state
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'hFF, 1);
    chk("rst_vld", 32'(vld0), 32'd0);
    chk("rst_gnt", 32'(gnt0), 32'd0);

    // Single requester, release, pointer advance
    step(1, 1, 8'h01, 0);
    chk("basic_gnt", 32'(gnt0), 32'h01);
    chk("basic_vld", 32'(vld0), 32'd1);
    step(1, 1, 8'h01, 1);
    chk("basic_rel_vld", 32'(vld0), 32'd0);
    step(1, 1, 8'h03, 0);
    chk("ptr_after_rel", 32'(id0), 32'd1);
    step(1, 1, 8'h00, 0);
    chk("req_drop_vld", 32'(vld0), 32'd0);

    // Round robin with all requesting, rel pulsed every grant
    step(0, 0, 8'h00, 0);
    for (int k = 0; k < 9; k++) begin
      step(1, 1, 8'hFF, 1);
      chk("rr_id", 32'(id0), 32'(k % 8));
      chk("rr_vld", 32'(vld0), 32'd1);
      step(1, 1, 8'hFF, 1);
      chk("rr_gap", 32'(vld0), 32'd0);
    end

    // Hold limit of 4 cycles
    step(0, 0, 8'h00, 0);
    for (int c = 0; c < 4; c++) begin
      step(1, 1, 8'h10, 0);
      chk("to_hold_vld", 32'(vld0), 32'd1);
      chk("to_hold_id", 32'(id0), 32'd4);
    end
    step(1, 1, 8'h10, 0);
    chk("to_end_vld", 32'(vld0), 32'd0);
    chk("to_pulse", 32'(to0), 32'd1);
    step(1, 1, 8'h10, 0);
    chk("to_regrant", 32'(id0), 32'd4);
    chk("to_pulse_clear", 32'(to0), 32'd0);

    // Release in the limit cycle ends without timeout
    step(0, 0, 8'h00, 0);
    for (int c = 0; c < 4; c++) step(1, 1, 8'h10, 0);
    step(1, 1, 8'h10, 1);
    chk("sim_vld", 32'(vld0), 32'd0);
    chk("sim_timeout", 32'(to0), 32'd0);

    // Wrap 7->0 and enable gating
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h40, 0);
    step(1, 1, 8'h40, 1);
    step(1, 1, 8'h81, 0);
    chk("wrap_id7", 32'(id0), 32'd7);
    step(1, 1, 8'h81, 1);
    step(1, 1, 8'h81, 0);
    chk("wrap_id0", 32'(id0), 32'd0);
    step(1, 0, 8'h81, 0);
    chk("en_hold", 32'(vld0), 32'd1);
    step(1, 0, 8'h81, 1);
    chk("en_rel", 32'(vld0), 32'd0);
    step(1, 0, 8'h81, 0);
    chk("en_block", 32'(vld0), 32'd0);
    step(1, 0, 8'h81, 0);
    chk("en_block2", 32'(vld0), 32'd0);

    // Reset mid-grant
    step(1, 1, 8'h81, 0);
    chk("mid_pre_vld", 32'(vld0), 32'd1);
    step(0, 1, 8'h81, 0);
    chk("mid_rst_vld", 32'(vld0), 32'd0);
    chk("mid_rst_gnt", 32'(gnt0), 32'd0);
    chk("mid_rst_to", 32'(to0), 32'd0);
    step(1, 1, 8'h06, 0);
    chk("mid_regrant", 32'(id0), 32'd1);

    // Randomised traffic
    rq = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      bit r, e, l;
      r = ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 99) < 85);
      l = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 9) >= 7) begin
        if ($urandom_range(0, 3) == 0) rq = 8'h01 << $urandom_range(0, 7);
        else rq = 8'($urandom);
      end
      step(r, e, rq, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum consecutive cycles one grant SHALL be held; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-004 en  input  1  arbitration enable; gates new grants only.
REQ-005 req  input  8  request lines; bit i = requester i.
REQ-006 rel  input  1  release strobe from the current holder.
REQ-007 gnt  output  8  one-hot grant; all zero when no grant is active.
REQ-008 gnt_id  output  3  binary index of the granted requester; 0 when no grant is active.
REQ-009 gnt_vld  output  1  high while a grant is held.
REQ-010 timeout  output  1  one-cycle pulse marking a grant revoked by the hold limit.
REQ-011 All outputs SHALL be registered.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (gnt_vld=0) and GRANT (gnt_vld=1).
REQ-013 IDLE->GRANT: when en=1 and req!=0 are sampled in cycle N, gnt_vld SHALL be 1 in cycle N+1 (one-cycle latency).
REQ-014 Winner SHALL be the first set req bit searching upward from rotating pointer ptr, wrapping 7->0 (round-robin).
REQ-015 In GRANT, gnt SHALL equal 1<<gnt_id, and gnt/gnt_id SHALL remain stable until the grant ends.
REQ-016 Grant end conditions, sampled while in GRANT: rel=1, req[gnt_id]=0, or hold count reaching TIMEOUT.
REQ-017 Hold counter (16 bit): 0 in the first GRANT cycle, +1 each GRANT cycle; a grant SHALL last at most TIMEOUT cycles.
REQ-018 GRANT->IDLE SHALL occur on the edge after an end condition; gnt, gnt_id and gnt_vld SHALL be 0 in the following cycle.
REQ-019 After every grant, at least one IDLE cycle SHALL occur before the next grant (no back-to-back grants).
REQ-020 On leaving GRANT, ptr SHALL become (gnt_id+1) mod 8.
REQ-021 timeout SHALL be 1 only in the first IDLE cycle after a timeout-caused end, otherwise 0.
REQ-022 If rel=1 or req[gnt_id]=0 in the same cycle the limit is reached, the end is a release: timeout SHALL stay 0.
REQ-023 en=0 SHALL block IDLE->GRANT but SHALL NOT abort an active grant.
REQ-024 req changes on non-granted bits during GRANT SHALL have no effect until the next IDLE evaluation.
REQ-025 rel while in IDLE SHALL be ignored.
REQ-026 TIMEOUT=1: every grant SHALL last exactly one cycle, with timeout pulsing unless released in that cycle.

Reset
REQ-027 With rst=0 at a rising edge: state=IDLE, ptr=0, counter=0, gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
REQ-028 Reset asserted mid-grant SHALL drop the grant on that edge without a timeout pulse.
REQ-029 Arbitration SHALL begin on the first edge with rst=1; earliest grant is visible one cycle later.

Verification
REQ-030 Reset, en=1, req=8'h01 -> next cycle gnt=8'h01, gnt_id=0, gnt_vld=1; rel pulse -> next cycle gnt_vld=0, ptr=1.
REQ-031 Round-robin: req=8'hFF held, rel pulsed each grant -> gnt_id sequence 0,1,...,7,0, each separated by one IDLE cycle.
REQ-032 Timeout: TIMEOUT=4, req=8'h10 held, rel=0 -> gnt_vld high exactly 4 cycles, then one cycle of gnt_vld=0 with timeout=1, then regrant of id 4.
REQ-033 Simultaneous: TIMEOUT=4, rel=1 in the 4th grant cycle -> grant ends with timeout=0.
REQ-034 Wrap and enable: ptr=7, req=8'h81 -> id 7 granted, then id 0; en=0 mid-grant -> grant held to rel, then no new grant while en=0.
REQ-035 Reset mid-grant: rst=0 during GRANT -> next cycle all outputs 0, timeout=0; after release of reset with req=8'h06 -> id 1 granted (ptr back to 0).
